// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT_HI = 2'd0,
        BOOT_LO = 2'd1,
        FETCH   = 2'd2,
        IMM     = 2'd3
    } fetch_state_e;

    localparam logic [15:0] NOP_WORD = 16'h07F8;
    localparam int          DEST_LSB = 3;
    localparam int          DEST_MSB = 6;

    // NOP carrying the destination field of a two-word instruction, so forwarding sees it a cycle early.
    function automatic logic [15:0] bubble_with_dest(input logic [15:0] word);
        logic [15:0] res;
        res = NOP_WORD;
        res[DEST_MSB:DEST_LSB] = word[DEST_MSB:DEST_LSB];
        return res;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: instruction memory read, hazard/branch requests and the IF/ID register outputs.
interface fetch_sequencer_if;

    logic [15:0] imem_word;
    logic        stall;
    logic        flush;
    logic [31:0] flush_target;
    logic [31:0] pc;
    logic [15:0] ir_instr;
    logic [15:0] ir_imm;
    logic        ir_valid;
    logic        bubble;
    logic        booting;

    modport master (
        input  imem_word, stall, flush, flush_target,
        output pc, ir_instr, ir_imm, ir_valid, bubble, booting
    );

    modport slave (
        output imem_word, stall, flush, flush_target,
        input  pc, ir_instr, ir_imm, ir_valid, bubble, booting
    );

endinterface

// File: rtl/fetch_sequencer_pc_reg.sv
// 32-bit program counter with load, hold and increment controls; increment wraps modulo 2^32.
module pc_reg #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic        inc_i,
    input  logic        hold_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Next PC: a load (redirect or boot) beats hold, hold beats increment.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (hold_i) begin
            pc_d = pc_q;
        end else if (inc_i) begin
            pc_d = pc_q + 32'd1;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: boots the PC, splits two-word instructions and drives the IF/ID register.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned IMM_BIT  = 2,
    parameter bit          BOOT_EN  = 1'b1,
    parameter logic [31:0] RESET_PC = 32'h0000_0020
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  bus
);

    localparam fetch_state_e STATE_RST = BOOT_EN ? BOOT_HI : FETCH;
    localparam logic [31:0]  PC_RST    = BOOT_EN ? 32'h0000_0000 : RESET_PC;

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_hi_q, pc_hi_d;
    logic [15:0]  held_q, held_d;
    logic [15:0]  ir_instr_q, ir_instr_d;
    logic [15:0]  ir_imm_q, ir_imm_d;
    logic         ir_valid_q, ir_valid_d;
    logic         bubble_q, bubble_d;
    logic         booting_q, booting_d;

    logic         flush_s;
    logic         pc_load_s;
    logic [31:0]  pc_load_val_s;
    logic         pc_inc_s;
    logic         pc_hold_s;
    logic [31:0]  pc_s;

    pc_reg #(
        .RESET_VAL (PC_RST)
    ) u_pc_reg (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (pc_load_s),
        .load_val_i (pc_load_val_s),
        .inc_i      (pc_inc_s),
        .hold_i     (pc_hold_s),
        .pc_o       (pc_s)
    );

    // Next-state and IF/ID register contents; redirects are not accepted while the boot vector loads.
    always_comb begin
        state_d       = state_q;
        pc_hi_d       = pc_hi_q;
        held_d        = held_q;
        ir_instr_d    = ir_instr_q;
        ir_imm_d      = ir_imm_q;
        ir_valid_d    = ir_valid_q;
        bubble_d      = bubble_q;
        booting_d     = booting_q;
        pc_load_s     = 1'b0;
        pc_load_val_s = 32'h0000_0000;
        pc_inc_s      = 1'b0;
        pc_hold_s     = 1'b0;
        flush_s       = bus.flush && ((state_q == FETCH) || (state_q == IMM));

        if (flush_s) begin
            pc_load_s     = 1'b1;
            pc_load_val_s = bus.flush_target;
            state_d       = FETCH;
            held_d        = 16'h0000;
            ir_instr_d    = NOP_WORD;
            ir_imm_d      = 16'h0000;
            ir_valid_d    = 1'b0;
            bubble_d      = 1'b1;
        end else if (bus.stall) begin
            pc_hold_s = 1'b1;
        end else begin
            case (state_q)
                BOOT_HI: begin
                    pc_hi_d       = bus.imem_word;
                    pc_load_s     = 1'b1;
                    pc_load_val_s = 32'h0000_0001;
                    state_d       = BOOT_LO;
                    ir_instr_d    = NOP_WORD;
                    ir_imm_d      = 16'h0000;
                    ir_valid_d    = 1'b0;
                    bubble_d      = 1'b1;
                    booting_d     = 1'b1;
                end
                BOOT_LO: begin
                    pc_load_s     = 1'b1;
                    pc_load_val_s = {pc_hi_q, bus.imem_word};
                    state_d       = FETCH;
                    ir_instr_d    = NOP_WORD;
                    ir_imm_d      = 16'h0000;
                    ir_valid_d    = 1'b0;
                    bubble_d      = 1'b1;
                    booting_d     = 1'b0;
                end
                FETCH: begin
                    pc_inc_s = 1'b1;
                    ir_imm_d = 16'h0000;
                    if (bus.imem_word[IMM_BIT]) begin
                        held_d     = bus.imem_word;
                        state_d    = IMM;
                        ir_instr_d = bubble_with_dest(bus.imem_word);
                        ir_valid_d = 1'b0;
                        bubble_d   = 1'b1;
                    end else begin
                        ir_instr_d = bus.imem_word;
                        ir_valid_d = 1'b1;
                        bubble_d   = 1'b0;
                    end
                end
                IMM: begin
                    // This word is the immediate, so its IMM_BIT is deliberately not examined.
                    pc_inc_s   = 1'b1;
                    state_d    = FETCH;
                    held_d     = 16'h0000;
                    ir_instr_d = held_q;
                    ir_imm_d   = bus.imem_word;
                    ir_valid_d = 1'b1;
                    bubble_d   = 1'b0;
                end
                default: begin
                    state_d    = STATE_RST;
                    held_d     = 16'h0000;
                    ir_instr_d = NOP_WORD;
                    ir_imm_d   = 16'h0000;
                    ir_valid_d = 1'b0;
                    bubble_d   = 1'b1;
                end
            endcase
        end
    end

    // FSM state, boot/held words and IF/ID output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= STATE_RST;
            pc_hi_q    <= 16'h0000;
            held_q     <= 16'h0000;
            ir_instr_q <= NOP_WORD;
            ir_imm_q   <= 16'h0000;
            ir_valid_q <= 1'b0;
            bubble_q   <= 1'b1;
            booting_q  <= BOOT_EN;
        end else begin
            state_q    <= state_d;
            pc_hi_q    <= pc_hi_d;
            held_q     <= held_d;
            ir_instr_q <= ir_instr_d;
            ir_imm_q   <= ir_imm_d;
            ir_valid_q <= ir_valid_d;
            bubble_q   <= bubble_d;
            booting_q  <= booting_d;
        end
    end

    assign bus.pc       = pc_s;
    assign bus.ir_instr = ir_instr_q;
    assign bus.ir_imm   = ir_imm_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.bubble   = bubble_q;
    assign bus.booting  = booting_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, reset corner cases, random run vs reference model.
module tb_fetch_sequencer;

    localparam logic [15:0] NOP    = 16'h07F8;
    localparam logic [15:0] DMASK  = 16'h0078;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] target;
        logic [31:0] pc;
        logic [15:0] instr;
        logic [15:0] imm;
        logic        valid;
        logic        bubble;
        logic        booting;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] mem [0:1023];
    int          checks;
    int          errors;
    vec_t        vecs [21];

    // Reference model state (random phase)
    logic [31:0] m_pc;
    logic [15:0] m_hi;
    int          m_boot;
    logic [15:0] m_pend [$];
    logic [15:0] e_instr;
    logic [15:0] e_imm;
    logic        e_valid;
    logic        e_bubble;

    fetch_sequencer_if bus_a ();
    fetch_sequencer_if bus_b ();

    fetch_sequencer #(.IMM_BIT(2), .BOOT_EN(1'b1), .RESET_PC(32'h0000_0020)) u_dut (
        .clk (clk), .rst (rst), .bus (bus_a.master)
    );
    fetch_sequencer #(.IMM_BIT(2), .BOOT_EN(1'b0), .RESET_PC(32'h0000_0020)) u_dut_nb (
        .clk (clk), .rst (rst), .bus (bus_b.master)
    );

    assign bus_a.imem_word = mem[bus_a.pc[9:0]];
    assign bus_b.imem_word = mem[bus_b.pc[9:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [31:0] pc, input logic [15:0] instr,
                           input logic [15:0] imm, input logic valid, input logic bubble,
                           input logic booting);
        check({tag, ".pc"},      bus_a.pc, pc);
        check({tag, ".instr"},   {16'h0000, bus_a.ir_instr}, {16'h0000, instr});
        check({tag, ".imm"},     {16'h0000, bus_a.ir_imm}, {16'h0000, imm});
        check({tag, ".valid"},   {31'h0, bus_a.ir_valid}, {31'h0, valid});
        check({tag, ".bubble"},  {31'h0, bus_a.bubble}, {31'h0, bubble});
        check({tag, ".booting"}, {31'h0, bus_a.booting}, {31'h0, booting});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input logic fl, input logic [31:0] tg,
                                input logic [31:0] pc, input logic [15:0] ins, input logic [15:0] imm,
                                input logic v, input logic b, input logic bt);
        vec_t r;
        r.stall = st; r.flush = fl; r.target = tg; r.pc = pc; r.instr = ins;
        r.imm = imm; r.valid = v; r.bubble = b; r.booting = bt;
        return r;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0000_0000;
        m_hi = 16'h0000;
        m_boot = 2;
        m_pend.delete();
        e_instr = NOP; e_imm = 16'h0000; e_valid = 1'b0; e_bubble = 1'b1;
    endtask

    task automatic model_bubble(input logic [15:0] ins);
        e_instr = ins; e_imm = 16'h0000; e_valid = 1'b0; e_bubble = 1'b1;
    endtask

    // One clock edge of the intended behaviour, in terms of the fetch stream.
    task automatic model_step(input logic st, input logic fl, input logic [31:0] tg);
        logic [15:0] word;
        word = mem[m_pc[9:0]];
        if (m_boot > 0) begin
            if (!st) begin
                if (m_boot == 2) begin
                    m_hi = word;
                    m_pc = 32'h0000_0001;
                end else begin
                    m_pc = {m_hi, word};
                end
                m_boot = m_boot - 1;
                model_bubble(NOP);
            end
        end else if (fl) begin
            m_pc = tg;
            m_pend.delete();
            model_bubble(NOP);
        end else if (!st) begin
            if (m_pend.size() > 0) begin
                e_instr = m_pend.pop_front();
                e_imm = word; e_valid = 1'b1; e_bubble = 1'b0;
            end else if (word[2]) begin
                m_pend.push_back(word);
                model_bubble((NOP & ~DMASK) | (word & DMASK));
            end else begin
                e_instr = word; e_imm = 16'h0000; e_valid = 1'b1; e_bubble = 1'b0;
            end
            m_pc = m_pc + 32'd1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_a.stall = 1'b0; bus_a.flush = 1'b0; bus_a.flush_target = 32'h0;
        bus_b.stall = 1'b0; bus_b.flush = 1'b0; bus_b.flush_target = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h001] = 16'h0040;
        mem[10'h020] = 16'h4560;
        mem[10'h040] = 16'h1230; mem[10'h041] = 16'h4560;
        mem[10'h042] = 16'h2A4C; mem[10'h043] = 16'hBEEF;
        mem[10'h044] = 16'h2A4C; mem[10'h045] = 16'h0004;
        mem[10'h046] = 16'h1230; mem[10'h047] = 16'h2A4C;
        mem[10'h048] = 16'hBEEF; mem[10'h049] = 16'h4560;
        mem[10'h04A] = 16'h2A4C; mem[10'h100] = 16'h1230;
        mem[10'h3FF] = 16'h4560;

        vecs[0]  = mk(0, 0, 32'h0,         32'h0000_0001, NOP,      16'h0000, 0, 1, 1);
        vecs[1]  = mk(0, 0, 32'h0,         32'h0000_0040, NOP,      16'h0000, 0, 1, 0);
        vecs[2]  = mk(0, 0, 32'h0,         32'h0000_0041, 16'h1230, 16'h0000, 1, 0, 0);
        vecs[3]  = mk(0, 0, 32'h0,         32'h0000_0042, 16'h4560, 16'h0000, 1, 0, 0);
        vecs[4]  = mk(0, 0, 32'h0,         32'h0000_0043, 16'h07C8, 16'h0000, 0, 1, 0);
        vecs[5]  = mk(0, 0, 32'h0,         32'h0000_0044, 16'h2A4C, 16'hBEEF, 1, 0, 0);
        vecs[6]  = mk(0, 0, 32'h0,         32'h0000_0045, 16'h07C8, 16'h0000, 0, 1, 0);
        vecs[7]  = mk(0, 0, 32'h0,         32'h0000_0046, 16'h2A4C, 16'h0004, 1, 0, 0);
        vecs[8]  = mk(0, 0, 32'h0,         32'h0000_0047, 16'h1230, 16'h0000, 1, 0, 0);
        vecs[9]  = mk(0, 0, 32'h0,         32'h0000_0048, 16'h07C8, 16'h0000, 0, 1, 0);
        vecs[10] = mk(1, 0, 32'h0,         32'h0000_0048, 16'h07C8, 16'h0000, 0, 1, 0);
        vecs[11] = mk(1, 0, 32'h0,         32'h0000_0048, 16'h07C8, 16'h0000, 0, 1, 0);
        vecs[12] = mk(1, 0, 32'h0,         32'h0000_0048, 16'h07C8, 16'h0000, 0, 1, 0);
        vecs[13] = mk(0, 0, 32'h0,         32'h0000_0049, 16'h2A4C, 16'hBEEF, 1, 0, 0);
        vecs[14] = mk(0, 0, 32'h0,         32'h0000_004A, 16'h4560, 16'h0000, 1, 0, 0);
        vecs[15] = mk(0, 0, 32'h0,         32'h0000_004B, 16'h07C8, 16'h0000, 0, 1, 0);
        vecs[16] = mk(1, 1, 32'h100,       32'h0000_0100, NOP,      16'h0000, 0, 1, 0);
        vecs[17] = mk(0, 0, 32'h0,         32'h0000_0101, 16'h1230, 16'h0000, 1, 0, 0);
        vecs[18] = mk(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NOP,      16'h0000, 0, 1, 0);
        vecs[19] = mk(0, 0, 32'h0,         32'h0000_0000, 16'h4560, 16'h0000, 1, 0, 0);
        vecs[20] = mk(0, 0, 32'h0,         32'h0000_0001, 16'h0000, 16'h0000, 1, 0, 0);

        // Reset state of both configurations
        #1 rst = 1'b0;
        #2;
        check_a("reset", 32'h0, NOP, 16'h0000, 1'b0, 1'b1, 1'b1);
        check("nb_reset.pc", bus_b.pc, 32'h0000_0020);
        check("nb_reset.booting", {31'h0, bus_b.booting}, 32'h0);
        check("nb_reset.bubble", {31'h0, bus_b.bubble}, 32'h1);
        #5 rst = 1'b1;

        for (int i = 0; i < 21; i++) begin
            bus_a.stall = vecs[i].stall;
            bus_a.flush = vecs[i].flush;
            bus_a.flush_target = vecs[i].target;
            tick();
            check_a($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].imm,
                    vecs[i].valid, vecs[i].bubble, vecs[i].booting);
            if (i == 0) begin
                check("nb_first.pc", bus_b.pc, 32'h0000_0021);
                check("nb_first.instr", {16'h0, bus_b.ir_instr}, 32'h0000_4560);
                check("nb_first.valid", {31'h0, bus_b.ir_valid}, 32'h1);
            end
        end

        // Async reset while the second word of a two-word instruction is pending
        bus_a.stall = 1'b0; bus_a.flush = 1'b1; bus_a.flush_target = 32'h0000_0044;
        tick();
        bus_a.flush = 1'b0;
        tick();
        check_a("pre_rst_imm", 32'h0000_0045, 16'h07C8, 16'h0000, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_a("rst_mid_imm", 32'h0, NOP, 16'h0000, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        check_a("post_rst_boot", 32'h0000_0001, NOP, 16'h0000, 1'b0, 1'b1, 1'b1);

        // Random run against the reference model
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_a("rnd_reset", m_pc, e_instr, e_imm, e_valid, e_bubble, 1'b1);
        rst = 1'b1;
        for (int c = 0; c < 400; c++) begin
            logic        st;
            logic        fl;
            logic [31:0] tg;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            tg = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
            bus_a.stall = st;
            bus_a.flush = fl;
            bus_a.flush_target = tg;
            tick();
            model_step(st, fl, tg);
            check_a($sformatf("rnd%0d", c), m_pc, e_instr, e_imm, e_valid, e_bubble, (m_boot > 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the 16-bit pipelined core. It owns the PC, boots it from the reset vector stored in instruction memory, and splits two-word (immediate-carrying) instructions into a bubble cycle plus one combined instruction/immediate issue. It applies stall and flush requests from the hazard and branch logic, and drives the IF/ID pipeline register.

## Interface
- `IMM_BIT`, default 2: instruction bit that marks a two-word instruction.
- `BOOT_EN`, default 1: 1 fetches the PC from memory words 0 (high half) and 1 (low half); 0 starts fetching directly at `RESET_PC`.
- `RESET_PC`, default 32'h0000_0020: start PC when `BOOT_EN`=0.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `imem_word` in 16: instruction-memory data at `pc`; combinational read in the same cycle.
- `stall` in 1: hazard unit request to hold PC, state and all outputs.
- `flush` in 1: redirect request (taken branch, jump or call).
- `flush_target` in 32: new PC when `flush`=1.
- `pc` out 32: fetch address.
- `ir_instr` out 16: instruction to ID.
- `ir_imm` out 16: immediate to ID; valid only with a two-word instruction.
- `ir_valid` out 1: `ir_instr` is a real instruction.
- `bubble` out 1: the ID slot this cycle is an inserted NOP.
- `booting` out 1: high while the reset vector is being loaded.

## Operation
- States:
  - `BOOT_HI`: latch `imem_word` into `pc_hi`, then go to `BOOT_LO`.
  - `BOOT_LO`: set `pc` = {`pc_hi`, `imem_word`}, then go to `FETCH`.
  - `FETCH`: one-word instruction, or first word of a two-word instruction.
  - `IMM`: second word of a two-word instruction.
- Reset (asynchronous):
  - State = `BOOT_HI` and `pc`=0 if `BOOT_EN`=1; otherwise state = `FETCH` and `pc`=`RESET_PC`.
  - `ir_instr`=`NOP_WORD`, `ir_imm`=0, `ir_valid`=0, `bubble`=1, `booting`=`BOOT_EN`, `held`=0.
- `BOOT_HI`: on the clock edge, `pc`←1. `BOOT_LO`: on the clock edge, `pc` is loaded as above. Both states emit bubble outputs.
- `FETCH` with `imem_word[IMM_BIT]`=0:
  - `ir_instr`←`imem_word`, `ir_imm`←0, `ir_valid`←1, `bubble`←0.
  - `pc`←`pc`+1.
- `FETCH` with `imem_word[IMM_BIT]`=1:
  - `held`←`imem_word`, `pc`←`pc`+1, go to `IMM`.
  - Outputs: `ir_instr`←`NOP_WORD` with bits [6:3] replaced by `imem_word[6:3]` (the destination, so forwarding sees it early), `ir_valid`←0, `bubble`←1.
- `IMM`:
  - `ir_instr`←`held`, `ir_imm`←`imem_word`, `ir_valid`←1, `bubble`←0.
  - `pc`←`pc`+1, go to `FETCH`.
  - `imem_word[IMM_BIT]` is ignored here because this word is data.
- `stall`=1 with `flush`=0: `pc`, state, `held` and all outputs hold.
- `flush`=1:
  - Flush wins over `stall`; it is honoured in `FETCH` and `IMM` and ignored during boot.
  - `pc`←`flush_target`, state←`FETCH`, `held` is discarded.
  - Outputs: `ir_instr`←`NOP_WORD`, `ir_valid`←0, `bubble`←1.
- PC arithmetic wraps modulo 2^32: 32'hFFFF_FFFF+1 = 0.

## Timing
- Fetch-to-ID latency is 1 cycle: a word presented at `pc` in cycle n appears on `ir_*` after edge n.
- A two-word instruction takes 2 cycles: a bubble, then the instruction with its immediate in the same cycle.
- Boot takes 2 cycles; the first real fetch is at cycle 2 after `rst` deasserts.
- `stall` and `flush` are sampled on the clock edge. `flush` in cycle n makes `pc`=`flush_target` visible in cycle n+1.
- `rst` asserting mid-instruction, including in `IMM`, drops `held` immediately with no partial issue.
- All outputs are registered except `pc`, which is a register read directly.

## Structure
- Shared package `fetch_pkg`:
  - state enum {`BOOT_HI`, `BOOT_LO`, `FETCH`, `IMM`}
  - `NOP_WORD` = 16'h07F8
  - `DEST_LSB`=3, `DEST_MSB`=6
- Sub-module `pc_reg`: 32-bit register with asynchronous active-low reset, load, increment and hold inputs. The FSM and output register stay in `fetch_sequencer`.

## Test plan
- Boot: `BOOT_EN`=1, mem[0]=16'h0000, mem[1]=16'h0040 → `booting` high for 2 cycles, then `pc`=32'h40, and the first `ir_valid` comes 1 cycle later.
- One-word stream: 16'h1230, 16'h4560 at 0x40/0x41 → `ir_instr` 1230 then 4560, `ir_valid`=1 each cycle, `pc` increments by 1.
- Two-word instruction: 16'h2A4C then 16'hBEEF:
  - First output is a bubble with `ir_instr`=16'h07C8 (dest bits copied).
  - Next cycle: `ir_instr`=2A4C, `ir_imm`=BEEF, `ir_valid`=1.
  - An immediate word of 16'h0004 (bit 2 set) must not be re-decoded.
- Stall in `IMM` for 3 cycles → `pc`, outputs and `held` frozen; the release cycle issues 2A4C/BEEF exactly once.
- Flush with simultaneous stall in `IMM`, target 32'h100 → next `pc`=32'h100, `bubble`=1, `held` discarded, state `FETCH`.
- Reset: `rst` low mid-`IMM` → outputs return to reset values immediately; `pc` wrap check 32'hFFFF_FFFF→0.
